// File: rtl/gsim_pkg.sv
// Shared constants and types for the GSIM residual checker.
package gsim_pkg;

  localparam int unsigned N  = 16;
  localparam int unsigned XW = 32;
  localparam int unsigned RW = 40;

  // Banded matrix taps, centre outwards; rows are symmetric.
  localparam int C0 = 20;
  localparam int C1 = -13;
  localparam int C2 = 6;
  localparam int C3 = -1;

  typedef enum logic {LOAD, CALC} state_e;

endpackage

// File: rtl/gsim_row_mac.sv
// Combinational 7-tap row sum of the banded matrix, built from shifts and adds only.
module gsim_row_mac #(
  parameter int unsigned XW = 32,
  parameter int unsigned RW = 40
) (
  input  logic [6:0][XW-1:0] taps_i,
  input  logic [6:0]         tap_en_i,
  output logic [RW-1:0]      sum_o
);

  logic [RW-1:0] e [7];
  logic [RW-1:0] c0_sum, c1_pair, c2_pair, c3_pair;
  logic [RW-1:0] t20, t13, t6;

  always_comb begin
    for (int k = 0; k < 7; k++) begin
      e[k] = tap_en_i[k] ? {{(RW-XW){taps_i[k][XW-1]}}, taps_i[k]} : '0;
    end
    // Symmetric taps share one product per pair.
    c0_sum  = e[3];
    c1_pair = e[2] + e[4];
    c2_pair = e[1] + e[5];
    c3_pair = e[0] + e[6];
    t20     = (c0_sum << 4) + (c0_sum << 2);
    t13     = (c1_pair << 3) + (c1_pair << 2) + c1_pair;
    t6      = (c2_pair << 2) + (c2_pair << 1);
    // Intermediate wrap is harmless: the exact result fits in RW bits.
    sum_o   = t20 - t13 + t6 - c3_pair;
  end

endmodule

// File: rtl/gsim_residual.sv
// Captures b and x frames, then streams r = M*x - b one row per cycle with a max-|r| summary.
module gsim_residual #(
  parameter int unsigned N  = 16,
  parameter int unsigned XW = 32,
  parameter int unsigned RW = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_en,
  input  logic signed [15:0]   b_in,
  input  logic                 x_valid,
  input  logic signed [XW-1:0] x_in,
  output logic                 r_valid,
  output logic [3:0]           r_idx,
  output logic [RW-1:0]        r_out,
  output logic                 done,
  output logic [RW-1:0]        max_abs
);

  import gsim_pkg::*;

  localparam logic [4:0] CntFull = 5'(N);
  localparam logic [3:0] JLast   = 4'(N - 1);

  state_e        state_q, state_d;
  logic [4:0]    b_cnt_q, b_cnt_d, x_cnt_q, x_cnt_d;
  logic [3:0]    j_q, j_d;
  logic [15:0]   bmem_q [N];
  logic [15:0]   bmem_d [N];
  logic [XW-1:0] xmem_q [N];
  logic [XW-1:0] xmem_d [N];
  logic          r_valid_q, r_valid_d, done_q, done_d;
  logic [3:0]    r_idx_q, r_idx_d;
  logic [RW-1:0] r_out_q, r_out_d, max_abs_q, max_abs_d;

  logic [6:0][XW-1:0] taps;
  logic [6:0]         tap_en;
  logic [4:0]         tap_idx;
  logic [RW-1:0]      row_sum, b_ext, resid, resid_abs;

  // Negative offsets wrap to >=16, so bit 4 alone flags an out-of-range tap.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      tap_idx   = {1'b0, j_q} + 5'(k) - 5'd3;
      tap_en[k] = ~tap_idx[4];
      taps[k]   = tap_idx[4] ? '0 : xmem_q[tap_idx[3:0]];
    end
  end

  gsim_row_mac #(
    .XW(XW),
    .RW(RW)
  ) u_row_mac (
    .taps_i  (taps),
    .tap_en_i(tap_en),
    .sum_o   (row_sum)
  );

  always_comb begin
    b_ext     = {{(RW-32){bmem_q[j_q][15]}}, bmem_q[j_q], 16'b0};
    resid     = row_sum - b_ext;
    resid_abs = resid[RW-1] ? (~resid + 1'b1) : resid;
  end

  always_comb begin
    state_d   = state_q;
    b_cnt_d   = b_cnt_q;
    x_cnt_d   = x_cnt_q;
    j_d       = j_q;
    bmem_d    = bmem_q;
    xmem_d    = xmem_q;
    r_valid_d = 1'b0;
    done_d    = 1'b0;
    r_idx_d   = r_idx_q;
    r_out_d   = r_out_q;
    max_abs_d = max_abs_q;
    unique case (state_q)
      LOAD: begin
        if (in_en && (b_cnt_q < CntFull)) begin
          bmem_d[b_cnt_q[3:0]] = b_in;
          b_cnt_d              = b_cnt_q + 5'd1;
        end
        if (x_valid && (x_cnt_q < CntFull)) begin
          xmem_d[x_cnt_q[3:0]] = x_in;
          x_cnt_d              = x_cnt_q + 5'd1;
        end
        if ((b_cnt_d == CntFull) && (x_cnt_d == CntFull)) begin
          state_d = CALC;
          j_d     = 4'd0;
        end
      end
      CALC: begin
        r_valid_d = 1'b1;
        r_idx_d   = j_q;
        r_out_d   = resid;
        if ((j_q == 4'd0) || (resid_abs > max_abs_q)) begin
          max_abs_d = resid_abs;
        end
        if (j_q == JLast) begin
          done_d  = 1'b1;
          state_d = LOAD;
          b_cnt_d = 5'd0;
          x_cnt_d = 5'd0;
          j_d     = 4'd0;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      b_cnt_q   <= 5'd0;
      x_cnt_q   <= 5'd0;
      j_q       <= 4'd0;
      r_valid_q <= 1'b0;
      done_q    <= 1'b0;
      r_idx_q   <= 4'd0;
      r_out_q   <= '0;
      max_abs_q <= '0;
    end else begin
      state_q   <= state_d;
      b_cnt_q   <= b_cnt_d;
      x_cnt_q   <= x_cnt_d;
      j_q       <= j_d;
      r_valid_q <= r_valid_d;
      done_q    <= done_d;
      r_idx_q   <= r_idx_d;
      r_out_q   <= r_out_d;
      max_abs_q <= max_abs_d;
    end
  end

  // Frame storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    bmem_q <= bmem_d;
    xmem_q <= xmem_d;
  end

  assign r_valid = r_valid_q;
  assign r_idx   = r_idx_q;
  assign r_out   = r_out_q;
  assign done    = done_q;
  assign max_abs = max_abs_q;

endmodule

// File: tb/tb_gsim_residual.sv
// Directed and randomized frames checked against a 64-bit arithmetic model of r = M*x - b.
module tb_gsim_residual;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_en;
  logic signed [15:0] b_in;
  logic               x_valid;
  logic signed [31:0] x_in;
  logic               r_valid;
  logic [3:0]         r_idx;
  logic [39:0]        r_out;
  logic               done;
  logic [39:0]        max_abs;

  gsim_residual dut (
    .clk    (clk),
    .reset  (reset),
    .in_en  (in_en),
    .b_in   (b_in),
    .x_valid(x_valid),
    .x_in   (x_in),
    .r_valid(r_valid),
    .r_idx  (r_idx),
    .r_out  (r_out),
    .done   (done),
    .max_abs(max_abs)
  );

  always #5 clk = ~clk;

  int          nvec  = 0;
  int          nfail = 0;
  int          xv [16];
  shortint     bv [16];
  int          coef [7] = '{-1, 6, -13, 20, -13, 6, -1};
  longint      er [16];
  logic [39:0] emax;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic calc_model();
    longint s;
    longint a;
    int     idx;
    emax = '0;
    for (int j = 0; j < 16; j++) begin
      s = 0;
      for (int k = 0; k < 7; k++) begin
        idx = j + k - 3;
        if (idx >= 0 && idx < 16) s += longint'(coef[k]) * longint'(xv[idx]);
      end
      s -= longint'(bv[j]) * 64'sd65536;
      er[j] = s;
      a = (s < 0) ? -s : s;
      if (a > longint'(emax)) emax = a[39:0];
    end
  endtask

  task automatic offer(input bit do_b, input int bi, input bit do_x, input int xi);
    in_en   = do_b;
    b_in    = do_b ? bv[bi] : 16'h0;
    x_valid = do_x;
    x_in    = do_x ? xv[xi] : 32'h0;
    chk("load_rvalid", {63'b0, r_valid}, 64'd0);
    tick();
  endtask

  // mode 0: lockstep, 1: x first, 2: b first with a 17th b word, 3: random interleave
  task automatic send(input int mode);
    int bi, xi, guard;
    bit ob, ox;
    case (mode)
      0: for (int i = 0; i < 16; i++) offer(1'b1, i, 1'b1, i);
      1: begin
        for (int i = 0; i < 16; i++) offer(1'b0, 0, 1'b1, i);
        for (int i = 0; i < 16; i++) offer(1'b1, i, 1'b0, 0);
      end
      2: begin
        for (int i = 0; i < 16; i++) offer(1'b1, i, 1'b0, 0);
        in_en = 1'b1;
        b_in  = 16'($urandom);
        chk("load_rvalid", {63'b0, r_valid}, 64'd0);
        tick();
        for (int i = 0; i < 16; i++) offer(1'b0, 0, 1'b1, i);
      end
      default: begin
        bi = 0;
        xi = 0;
        guard = 0;
        while (bi < 16 || xi < 16) begin
          guard++;
          ob = (bi < 16) && ($urandom_range(1) == 1 || guard > 100);
          ox = (xi < 16) && ($urandom_range(1) == 1 || guard > 100);
          offer(ob, bi, ox, xi);
          if (ob) bi++;
          if (ox) xi++;
        end
      end
    endcase
    in_en   = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input bit junk);
    logic [39:0] e;
    calc_model();
    send(mode);
    if (junk) begin
      in_en   = 1'b1;
      x_valid = 1'b1;
      b_in    = 16'($urandom);
      x_in    = $urandom;
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      e = er[j][39:0];
      chk("r_valid", {63'b0, r_valid}, 64'd1);
      chk("r_idx", {60'b0, r_idx}, 64'(j));
      chk("r_out", {24'b0, r_out}, {24'b0, e});
      chk("done", {63'b0, done}, (j == 15) ? 64'd1 : 64'd0);
      if (j == 15) chk("max_abs", {24'b0, max_abs}, {24'b0, emax});
    end
    in_en   = 1'b0;
    x_valid = 1'b0;
    tick();
    chk("post_rvalid", {63'b0, r_valid}, 64'd0);
    chk("post_done", {63'b0, done}, 64'd0);
    chk("max_hold", {24'b0, max_abs}, {24'b0, emax});
  endtask

  task automatic chk_reset_state();
    chk("rst_rvalid", {63'b0, r_valid}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_ridx", {60'b0, r_idx}, 64'd0);
    chk("rst_rout", {24'b0, r_out}, 64'd0);
    chk("rst_max", {24'b0, max_abs}, 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    in_en   = 1'b0;
    x_valid = 1'b0;
    b_in    = '0;
    x_in    = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_state();

    // x = 0, b = 1: every r = -1.0
    for (int i = 0; i < 16; i++) begin xv[i] = 0; bv[i] = 1; end
    run_frame(0, 1'b0);
    chk("t1_r15", {24'b0, r_out}, 64'hFF_FFFF_0000);
    chk("t1_max", {24'b0, max_abs}, 64'h00_0001_0000);

    // x = 1.0, b = 0: edge rows 12,-1,5 and interior 4
    for (int i = 0; i < 16; i++) begin xv[i] = 32'h0001_0000; bv[i] = 0; end
    run_frame(0, 1'b0);
    chk("t2_max", {24'b0, max_abs}, 64'h00_000C_0000);

    // x = 0, b = -32768
    for (int i = 0; i < 16; i++) begin xv[i] = 0; bv[i] = 16'sh8000; end
    run_frame(1, 1'b0);
    chk("t3_r15", {24'b0, r_out}, 64'h00_8000_0000);

    // Extreme alternating x exercises the full dynamic range.
    for (int i = 0; i < 16; i++) begin
      xv[i] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      bv[i] = 0;
    end
    run_frame(2, 1'b1);

    // Same random data in b-first and x-first order, then random frames.
    for (int i = 0; i < 16; i++) begin xv[i] = $urandom; bv[i] = 16'($urandom); end
    run_frame(2, 1'b0);
    run_frame(1, 1'b1);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 16; i++) begin
        xv[i] = (f % 2 == 0) ? $urandom : int'($urandom_range(32'h0004_0000)) - 32'h0002_0000;
        bv[i] = 16'($urandom);
      end
      run_frame(f % 4, f[0]);
    end

    // Reset after 8 x words discards the partial frame.
    for (int i = 0; i < 8; i++) begin
      x_valid = 1'b1;
      x_in    = $urandom;
      tick();
    end
    x_valid = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state();
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("part_rvalid", {63'b0, r_valid}, 64'd0);
    end
    for (int i = 0; i < 16; i++) begin xv[i] = $urandom; bv[i] = 16'($urandom); end
    run_frame(3, 1'b0);

    // Reset mid-CALC cuts the residual stream short.
    send(0);
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state();
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("calc_rst_rvalid", {63'b0, r_valid}, 64'd0);
    end
    for (int i = 0; i < 16; i++) begin xv[i] = $urandom; bv[i] = 16'($urandom); end
    run_frame(0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/gsim_residual.md
# gsim_residual

Downstream checker for the GSIM solver. Captures the 16-word `b` vector alongside GSIM's input, then the 16 `x` results GSIM emits on `out_valid`/`x_out`. It computes the residual r = M·x − b row by row, where M is the fixed 16×16 banded matrix with row taps −1, 6, −13, 20, −13, 6, −1, truncated at the edges. The residual stream and a max-|r| summary give on-chip convergence monitoring without a software reference.

## Interface
Parameters:
- `N`, 16: vector length. Fixed, carried for readability only.
- `XW`, 32: `x` width, signed Q16.16.
- `RW`, 40: residual width, signed Q24.16.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_en`, in, 1: `b_in` valid. Tied to GSIM's `in_en`.
- `b_in`, in, 16: signed integer b element, in index order 0..15.
- `x_valid`, in, 1: `x_in` valid. Tied to GSIM's `out_valid`.
- `x_in`, in, 32: signed Q16.16 x element, in index order 0..15.
- `r_valid`, out, 1: `r_out` and `r_idx` valid.
- `r_idx`, out, 4: row index of the current `r_out`.
- `r_out`, out, 40: signed Q24.16 residual (M·x)_j − b_j.
- `done`, out, 1: one-cycle pulse on the last residual.
- `max_abs`, out, 40: unsigned max |r_j| of the frame. Valid when `done`=1 and held until the next frame's first `r_valid`.

## Operation
- State `LOAD`:
  - `b_cnt` and `x_cnt` (0..16) advance independently.
  - The word on `b_in` is written to `bmem[b_cnt]` when `in_en`=1 and `b_cnt`<16.
  - The word on `x_in` is written to `xmem[x_cnt]` when `x_valid`=1 and `x_cnt`<16.
  - Words beyond 16 are dropped.
  - Both streams may be accepted in the same cycle, and may arrive in either order.
- `LOAD`→`CALC`: at the edge where both counts equal 16 (including the edge that accepts the 16th word).
- State `CALC`: row counter `j` runs 0..15, one row per cycle.
  - The row sum is −x[j−3] + 6x[j−2] − 13x[j−1] + 20x[j] − 13x[j+1] + 6x[j+2] − x[j+3].
  - Out-of-range taps contribute 0.
  - The sum is built by shift-and-add only (20=16+4, 13=8+4+1, 6=4+2); no multipliers.
  - b is sign-extended to RW, then shifted left 16, then subtracted from the row sum.
  - `in_en`/`x_valid` are ignored in `CALC`.
- `CALC`→`LOAD`: after row 15 is registered. Both counts clear to 0; the memories are not cleared.
- Width rule:
  - Σ|taps| = 60, so |M·x| < 60·2^31 < 2^37. Adding |b·2^16| ≤ 2^31 still fits in 38 bits.
  - No saturation or rounding is applied; the result is exact.
- `max_abs`: a running maximum of |r_j|, reset to 0 at row 0 of each frame.
  - |r| of the most negative 40-bit value cannot occur, because of the width rule above.
- Reset (any cycle, including mid-`CALC`):
  - state ← `LOAD`, counts ← 0, `j` ← 0.
  - `r_valid`=0, `done`=0, `r_idx`=0, `r_out`=0, `max_abs`=0.
  - A partial frame is discarded and no `r_valid` follows it.

## Timing
- All outputs are registered.
- Let E0 be the edge accepting the final word of the later stream. Row j is registered at edge E0+1+j.
- `r_valid` is high for exactly 16 consecutive cycles, with `r_idx` 0..15.
- `done`=1 and the final `max_abs` are presented in the same cycle as `r_idx`=15.
- A new frame's words are accepted from the cycle after `done` (edge E0+17 onward).
- Throughput: one frame per 16 + max(b, x arrival span) + 1 cycles.

## Structure
- `gsim_pkg` holds:
  - `N`, `XW`, `RW`;
  - the tap constants (C0=20, C1=−13, C2=6, C3=−1);
  - the state enum `{LOAD, CALC}`.
- Sub-module `gsim_row_mac`: combinational 7-tap shift-add.
  - Takes seven XW-bit taps plus a 7-bit tap-enable mask for edge truncation.
  - Returns an RW-bit sum.
- The top holds the memories, counters, FSM, subtraction and max tracking.

## Test plan
- All x=0x00000000, all b=1: r_j=0xFFFFFF0000 (−1.0) for every j; `max_abs`=0x0000010000; `done` with `r_idx`=15.
- All x=0x00010000 (1.0), all b=0: r in units of 0x10000 = 12, −1, 5, then 4 (×10, rows 3..12), then 5, −1, 12; `max_abs`=0x00000C0000.
- x=0, all b=0x8000 (−32768): every r_j=0x0080000000; `max_abs`=0x0080000000.
- Overflow case: x alternating 0x7FFFFFFF/0x80000000 starting with +, b=0.
  - Interior |r| is close to 60·2^31 with the sign matching that row's x[j].
  - Result is exact against a 64-bit model, no wrap.
- Ordering:
  - x stream fully before b stream → same residuals as b-first.
  - 17th `in_en` word in `LOAD` is dropped.
  - Words during `CALC` are dropped.
- Reset after 8 x words: no `r_valid`. A following full frame produces correct residuals with `max_abs` reset.
